bin_to_gray: RTL and testbench
==============================

Name: bin_to_gray

Overview:
- Registered binary-to-Gray-code converter, parameterizable width, default 4 bits.
- Samples a binary word every clock and presents its reflected-binary Gray code one cycle later.
- Carries a valid qualifier through the pipeline.
- Includes a loopback integrity check: Gray output is decoded back to binary and compared with the delayed input; mismatches raise a sticky error flag.
- Used as a counter/encoder front end wherever single-bit-change codes are needed, e.g. clock-domain-crossing pointers.

Parameters:
- WIDTH, 4, bit width of bin and gray; legal range 2..32.
- CHECK_EN, 1, 1 = include the loopback decoder and err output logic; 0 = err tied low.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- bin, input, WIDTH, binary value sampled every rising edge.
- bin_valid, input, 1, qualifies bin; tie high for free-running use.
- gray, output, WIDTH, registered Gray code of the previously sampled bin.
- gray_valid, output, 1, registered copy of bin_valid.
- err, output, 1, sticky loopback mismatch flag.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge): gray=0, gray_valid=0, err=0, internal delayed-bin register=0. rst has priority over all other inputs.
- Conversion rule: gray[WIDTH-1] = bin[WIDTH-1]; gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1. Equivalently, gray = bin XOR (bin >> 1), logical shift.
- Latency is exactly 1 cycle. The value of bin at edge N appears on gray after edge N, and gray_valid follows bin_valid with the same latency.
- When bin_valid=0 at an edge, gray holds its previous value and gray_valid=0. Holding keeps the output Gray-stable.
- No combinational path from bin to gray. gray, gray_valid and err are driven directly from flops.
- Wrap-around: bin all-ones (4'b1111) maps to gray=4'b1000. A following bin=0 maps to gray=0, a single-bit change. Consecutive binary values, including the wrap, always produce gray values differing in exactly one bit.
- Loopback check (CHECK_EN=1):
  - A decoder reconstructs binary from the gray register: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i].
  - The result is compared against the registered copy of the sampled bin whenever gray_valid=1.
  - On mismatch, err is set on the next edge and stays high until rst.
  - err never asserts in a correct implementation; it exists for fault and X detection in simulation and FPGA bring-up.
- Reset asserted mid-stream: at the reset edge, outputs go to 0 regardless of bin/bin_valid. The first valid output after reset appears one cycle after the first edge with rst=0 and bin_valid=1.
- X on bin while bin_valid=0 must not propagate to gray.

Decomposition:
- Package gray_pkg: default width constant GRAY_W_DEF=4.
- Package functions: bin2gray(logic[WIDTH-1:0]) and gray2bin(...), written as loops for any width. These are reusable by the bench as the reference model.
- One sub-module: gray_to_bin, a combinational decoder of WIDTH bits used by the loopback check. It is instantiated only when CHECK_EN=1, via a generate block.

Test Plan:
- Reset: hold rst=1 for 5 cycles with bin=4'b0101, bin_valid=1 -> gray=0, gray_valid=0, err=0 throughout. After release, the first edge gives gray=4'b0111.
- Full sweep: bin=0..15, one value per cycle, bin_valid=1 -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, each lagging bin by 1 cycle. Adjacent outputs differ in one bit; err stays 0.
- Wrap: bin 15 then 0 -> gray 1000 then 0000, a single-bit change.
- Valid gating: bin=4'b0110 valid, then bin=4'b1111 with bin_valid=0 for 3 cycles -> gray holds 0101 and gray_valid=0 for those cycles.
- Mid-stream reset: sweep in progress at bin=9, assert rst for 1 cycle -> next edge gray=0, gray_valid=0. Conversion resumes correctly on the following cycle.
- WIDTH=8 instance: bin=8'hFF -> gray=8'h80; bin=8'hA5 -> gray=8'hF7; err=0.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared definitions for the binary/Gray-code converter family.
//   - GRAY_W_DEF : default datapath width.
//   - GRAY_W_MAX : widest word the helper functions handle.
//   - bin2gray / gray2bin : width-agnostic helpers operating on a
//     GRAY_W_MAX-bit word. Narrower values are zero-extended by the
//     caller, and the result is truncated back. Zero upper bits convert
//     to zero upper bits in both directions, so truncation is exact.
package gray_pkg;

    localparam int GRAY_W_DEF = 4;
    localparam int GRAY_W_MAX = 32;

    // Reflected-binary encode: each Gray bit is the XOR of a binary bit
    // with its more significant neighbour; the MSB passes straight through.
    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        logic [GRAY_W_MAX-1:0] g;
        g[GRAY_W_MAX-1] = b[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Reflected-binary decode: running XOR from the MSB downwards.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg

// File: rtl/gray_to_bin.sv
// gray_to_bin
//   Purely combinational Gray-to-binary decoder.
//   Parameters:
//     WIDTH  : word width (2..32)
//   Ports:
//     gray_i : Gray-coded input word
//     bin_o  : decoded binary word
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEF
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Binary bit i is the XOR of every Gray bit at or above i. Writing it
    // as a reduction per bit avoids a self-referencing vector assignment.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
    end

endmodule : gray_to_bin

// File: rtl/bin_to_gray.sv
// bin_to_gray
//   Registered binary-to-Gray converter with a valid qualifier and an
//   optional loopback integrity check.
//   Parameters:
//     WIDTH      : width of bin and gray (2..32)
//     CHECK_EN   : 1 = build loopback decoder and sticky err; 0 = err low
//   Ports:
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset
//     bin        : binary word, sampled when bin_valid=1
//     bin_valid  : qualifies bin
//     gray       : registered Gray code of the last sampled bin
//     gray_valid : registered copy of bin_valid
//     err        : sticky loopback mismatch flag
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH    = GRAY_W_DEF,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin,
    input  logic             bin_valid,
    output logic [WIDTH-1:0] gray,
    output logic             gray_valid,
    output logic             err
);

    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             gray_valid_q, gray_valid_d;

    // Combinational encode feeding the output register only.
    assign conv[WIDTH-1] = bin[WIDTH-1];
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_enc
        assign conv[gi] = bin[gi+1] ^ bin[gi];
    end

    // An idle cycle keeps the last code, so the output never glitches
    // through an unrelated value; bin is ignored entirely (including X).
    always_comb begin
        gray_d       = gray_q;
        gray_valid_d = bin_valid;
        if (bin_valid) begin
            gray_d = conv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q       <= '0;
            gray_valid_q <= 1'b0;
        end else begin
            gray_q       <= gray_d;
            gray_valid_q <= gray_valid_d;
        end
    end

    assign gray       = gray_q;
    assign gray_valid = gray_valid_q;

    if (CHECK_EN) begin : g_check
        logic [WIDTH-1:0] bin_q, bin_d;
        logic [WIDTH-1:0] dec;
        logic             err_q, err_d;

        // bin_q is captured alongside gray_q so the two always describe
        // the same sample and can be compared directly.
        always_comb begin
            bin_d = bin_q;
            if (bin_valid) begin
                bin_d = bin;
            end
        end

        gray_to_bin #(
            .WIDTH (WIDTH)
        ) u_dec (
            .gray_i (gray_q),
            .bin_o  (dec)
        );

        // Sticky until reset; compared only while the output is qualified.
        always_comb begin
            err_d = err_q;
            if (gray_valid_q && (dec != bin_q)) begin
                err_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                bin_q <= '0;
                err_q <= 1'b0;
            end else begin
                bin_q <= bin_d;
                err_q <= err_d;
            end
        end

        assign err = err_q;
    end else begin : g_nocheck
        assign err = 1'b0;
    end

endmodule : bin_to_gray

// File: tb/tb_bin_to_gray.sv
module tb_bin_to_gray;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bin;
    logic       bin_valid;
    logic [3:0] gray;
    logic       gray_valid;
    logic       err;

    logic [7:0] bin8;
    logic       bin_valid8;
    logic [7:0] gray8;
    logic       gray_valid8;
    logic       err8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_gray  = '0;
    logic       m_gv    = 1'b0;
    logic [7:0] m_gray8 = '0;
    logic       m_gv8   = 1'b0;

    logic [3:0] prev_gray;

    always #5 clk = ~clk;

    bin_to_gray #(.WIDTH(4), .CHECK_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bin        (bin),
        .bin_valid  (bin_valid),
        .gray       (gray),
        .gray_valid (gray_valid),
        .err        (err)
    );

    bin_to_gray #(.WIDTH(8), .CHECK_EN(1'b1)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .bin        (bin8),
        .bin_valid  (bin_valid8),
        .gray       (gray8),
        .gray_valid (gray_valid8),
        .err        (err8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic r, input logic [3:0] b, input logic v,
                        input logic [7:0] b8, input logic v8, input string tag);
        rst        = r;
        bin        = b;
        bin_valid  = v;
        bin8       = b8;
        bin_valid8 = v8;
        @(posedge clk);
        #1;
        if (r) begin
            m_gray = '0; m_gv = 1'b0; m_gray8 = '0; m_gv8 = 1'b0;
        end else begin
            m_gv  = v;
            m_gv8 = v8;
            if (v)  m_gray  = b ^ (b >> 1);
            if (v8) m_gray8 = b8 ^ (b8 >> 1);
        end
        chk({tag, ".gray"},        32'(gray),        32'(m_gray));
        chk({tag, ".gray_valid"},  32'(gray_valid),  32'(m_gv));
        chk({tag, ".err"},         32'(err),         32'(0));
        chk({tag, ".gray8"},       32'(gray8),       32'(m_gray8));
        chk({tag, ".gray_valid8"}, 32'(gray_valid8), 32'(m_gv8));
        chk({tag, ".err8"},        32'(err8),        32'(0));
        $display("step %-10s rst=%b bin=%h v=%b -> gray=%h gv=%b err=%b | bin8=%h v8=%b -> gray8=%h gv8=%b err8=%b",
                 tag, r, b, v, gray, gray_valid, err, b8, v8, gray8, gray_valid8, err8);
    endtask

    initial begin
        rst = 1'b1; bin = '0; bin_valid = 1'b0; bin8 = '0; bin_valid8 = 1'b0;

        // Reset held with active input
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0101, 1'b1, 8'h5A, 1'b1, "reset");
        step(1'b0, 4'b0101, 1'b1, 8'h00, 1'b1, "release");
        chk("release.literal", 32'(gray), 32'h7);

        // Full sweep with single-bit-change property
        prev_gray = gray;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'(i), 1'b1, 8'(i * 17), 1'b1, "sweep");
            if (i > 0) chk("sweep.onebit", 32'($countones(gray ^ prev_gray)), 32'd1);
            prev_gray = gray;
        end
        chk("wrap.top", 32'(gray), 32'h8);
        step(1'b0, 4'h0, 1'b1, 8'hFF, 1'b1, "wrap");
        chk("wrap.zero", 32'(gray), 32'h0);
        chk("wrap.onebit", 32'($countones(gray ^ prev_gray)), 32'd1);
        chk("w8.ff", 32'(gray8), 32'h80);
        step(1'b0, 4'h1, 1'b1, 8'hA5, 1'b1, "w8a5");
        chk("w8.a5", 32'(gray8), 32'hF7);

        // Valid gating, including X on an unqualified input
        step(1'b0, 4'b0110, 1'b1, 8'h3C, 1'b1, "gate_v");
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b0, 8'hC3, 1'b0, "gate_h");
        chk("gate.hold", 32'(gray), 32'h5);
        step(1'b0, 4'bxxxx, 1'b0, 8'hxx, 1'b0, "gate_x");
        chk("gate.xhold", 32'(gray), 32'h5);

        // Mid-stream reset
        for (int i = 0; i <= 9; i++) step(1'b0, 4'(i), 1'b1, 8'(i), 1'b1, "pre_rst");
        step(1'b1, 4'hA, 1'b1, 8'hA, 1'b1, "mid_rst");
        step(1'b0, 4'hA, 1'b1, 8'hA, 1'b1, "resume");
        chk("resume.literal", 32'(gray), 32'hF);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 29) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bin_to_gray
